// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: reads one or two registers through the shared
// register-file port, runs an 8-bit ALU op, writes the result back and updates flags.
module alu_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rdst,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag
);

  // state  | meaning
  // IDLE   | waiting for start
  // READ_A | port reads rs1, operand A captured at the closing edge
  // READ_B | port reads rs2 (two-operand ops only)
  // EXEC   | ALU result and flags registered at the closing edge
  // WRITE  | one-cycle write of the result to rdst
  // DONE   | completion pulse, start ignored
  typedef enum logic [2:0] {
    S_IDLE, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        opcode_q;
  logic [ADDR_W-1:0] rs2_q, rdst_q;
  logic [DATA_W-1:0] op_a, op_b;
  logic              two_op;

  logic [DATA_W:0]   alu_full;
  logic [DATA_W-1:0] alu_res;

  logic [ADDR_W-1:0] rf_addr_nxt;
  logic              rf_rd_nxt, rf_wr_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] rf_wdata_nxt;

  assign two_op = (opcode_q <= 3'd4);

  always_comb begin
    alu_full = '0;
    case (opcode_q)
      3'd0:    alu_full = {1'b0, op_a} + {1'b0, op_b};
      3'd1:    alu_full = {1'b0, op_a} - {1'b0, op_b};  // bit DATA_W is the borrow
      3'd2:    alu_full = {1'b0, op_a & op_b};
      3'd3:    alu_full = {1'b0, op_a | op_b};
      3'd4:    alu_full = {1'b0, op_a ^ op_b};
      3'd5:    alu_full = {1'b0, ~op_a};
      3'd6:    alu_full = {op_a, 1'b0};
      default: alu_full = {1'b0, op_a};
    endcase
  end

  assign alu_res = alu_full[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_READ_A;
      S_READ_A: state_nxt = two_op ? S_READ_B : S_EXEC;
      S_READ_B: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    rf_addr_nxt  = '0;
    rf_rd_nxt    = 1'b0;
    rf_wr_nxt    = 1'b0;
    rf_wdata_nxt = '0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state_nxt)
      S_READ_A: begin
        rf_addr_nxt = rs1;
        rf_rd_nxt   = 1'b1;
        busy_nxt    = 1'b1;
      end
      S_READ_B: begin
        rf_addr_nxt = rs2_q;
        rf_rd_nxt   = 1'b1;
        busy_nxt    = 1'b1;
      end
      S_EXEC:  busy_nxt = 1'b1;
      S_WRITE: begin
        rf_addr_nxt  = rdst_q;
        rf_wr_nxt    = 1'b1;
        rf_wdata_nxt = alu_res;
        busy_nxt     = 1'b1;
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_addr    <= '0;
      rf_rd      <= 1'b0;
      rf_wr      <= 1'b0;
      rf_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      opcode_q   <= '0;
      rs2_q      <= '0;
      rdst_q     <= '0;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      rf_addr  <= rf_addr_nxt;
      rf_rd    <= rf_rd_nxt;
      rf_wr    <= rf_wr_nxt;
      rf_wdata <= rf_wdata_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      if (state == S_IDLE && start) begin
        opcode_q <= opcode;
        rs2_q    <= rs2;
        rdst_q   <= rdst;
      end
      if (state == S_READ_A) op_a <= rf_rdata;
      if (state == S_READ_B) op_b <= rf_rdata;
      if (state == S_EXEC) begin
        result     <= alu_res;
        zero_flag  <= (alu_res == '0);
        carry_flag <= alu_full[DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: a behavioural 4x8 register file sits on the
// port, directed commands push expected reads/writes, a monitor pops and compares.
module tb_alu_exec_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    opcode;
  logic [AW-1:0] rs1, rs2, rdst, rf_addr;
  logic          rf_rd, rf_wr, busy, done, zero_flag, carry_flag;
  logic [DW-1:0] rf_wdata, rf_rdata, result;

  alu_exec_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rdst(rdst),
    .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy), .done(done), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register file model
  logic [DW-1:0] mem [4];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (rf_wr)       mem[rf_addr] <= rf_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign rf_rdata = rf_rd ? mem[rf_addr] : '0;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          z;
    logic          c;
    int            wr_cyc;
    logic          seen_wr;
  } wr_t;

  rd_t rd_q [$];
  wr_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got activity with addr %0d data 0x%0h, expected none (cycle %0d)",
             name, rf_addr, rf_wdata, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    if (rf_rd === 1'b1 && rf_wr === 1'b1) check("rd_wr_exclusive", 32'(rf_rd & rf_wr), 32'd0);
    if (rf_rd === 1'b1) begin
      if (rd_q.size() == 0) flag_unexpected("spurious_rf_rd");
      else begin
        r = rd_q.pop_front();
        check("rd_addr", 32'(rf_addr), 32'(r.addr));
        check("rd_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
    if (rf_wr === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].seen_wr) flag_unexpected("spurious_rf_wr");
      else begin
        w = exp_q[0];
        exp_q[0].seen_wr = 1'b1;
        check("wr_addr", 32'(rf_addr), 32'(w.addr));
        check("wr_data", 32'(rf_wdata), 32'(w.data));
        check("wr_cycle", 32'(cyc), 32'(w.wr_cyc));
      end
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) flag_unexpected("spurious_done");
      else begin
        w = exp_q.pop_front();
        check("done_after_write", 32'(w.seen_wr), 32'd1);
        check("done_cycle", 32'(cyc), 32'(w.wr_cyc + 1));
        check("done_busy", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(w.data));
        check("zero_flag", 32'(zero_flag), 32'(w.z));
        check("carry_flag", 32'(carry_flag), 32'(w.c));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending completions, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_rd_pending"}, 32'(rd_q.size()), 32'd0);
  endtask

  // Expected values are hand-computed and passed in by the caller.
  task automatic issue(input string name, input logic [2:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d,
                       input logic [DW-1:0] exp_data, input logic z, input logic c,
                       input bit hold);
    int base, lat;
    wr_t w;
    @(negedge clk);
    base = cyc;
    lat  = (op <= 3'd4) ? 4 : 3;
    rd_q.push_back('{addr: a, cyc: base + 1});
    if (op <= 3'd4) rd_q.push_back('{addr: b, cyc: base + 2});
    w = '{addr: d, data: exp_data, z: z, c: c, wr_cyc: base + lat, seen_wr: 1'b0};
    exp_q.push_back(w);
    start = 1'b1; opcode = op; rs1 = a; rs2 = b; rdst = d;
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        opcode = 3'($urandom_range(0, 7));
        rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3)); rdst = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
    end else begin
      @(negedge clk);
      start = 1'b0;
      opcode = 3'($urandom_range(0, 7));
      rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3)); rdst = 2'($urandom_range(0, 3));
    end
    drain(name);
    check({name, "_rf_value"}, 32'(mem[d]), 32'(exp_data));
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rdst = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({rf_addr, rf_rd, rf_wr, rf_wdata, busy, done, result, zero_flag, carry_flag}), 32'd0);
    reset = 1'b0;

    preload(2'd0, 8'h00); preload(2'd1, 8'h02); preload(2'd2, 8'h01); preload(2'd3, 8'h11);
    issue("add_basic", 3'd0, 2'd1, 2'd3, 2'd0, 8'h13, 1'b0, 1'b0, 1'b0);
    issue("sub_borrow", 3'd1, 2'd2, 2'd1, 2'd2, 8'hFF, 1'b0, 1'b1, 1'b0);
    preload(2'd3, 8'hF0); preload(2'd1, 8'h10);
    issue("add_wrap", 3'd0, 2'd3, 2'd1, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
    preload(2'd3, 8'h81);
    issue("shl_carry", 3'd6, 2'd3, 2'd0, 2'd1, 8'h02, 1'b0, 1'b1, 1'b0);
    issue("xor_same_src", 3'd4, 2'd3, 2'd3, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
    issue("not_a", 3'd5, 2'd1, 2'd0, 2'd0, 8'hFD, 1'b0, 1'b0, 1'b0);

    // abort an ADD in READ_B, with start also high on the reset edge
    begin
      int base;
      @(negedge clk);
      base = cyc;
      rd_q.push_back('{addr: 2'd0, cyc: base + 1});
      rd_q.push_back('{addr: 2'd1, cyc: base + 2});
      start = 1'b1; opcode = 3'd0; rs1 = 2'd0; rs2 = 2'd1; rdst = 2'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      check("abort_outputs",
            32'({rf_addr, rf_rd, rf_wr, rf_wdata, busy, done, result, zero_flag, carry_flag}), 32'd0);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("abort_start_dropped", 32'({busy, rf_rd}), 32'd0);
      check("abort_rd_pending", 32'(rd_q.size()), 32'd0);
      repeat (8) @(negedge clk);
      check("abort_dest_kept", 32'(mem[2]), 32'hFF);
    end

    issue("or_after_abort", 3'd3, 2'd1, 2'd2, 2'd3, 8'hFF, 1'b0, 1'b0, 1'b0);
    issue("and_zero", 3'd2, 2'd0, 2'd1, 2'd2, 8'h00, 1'b1, 1'b0, 1'b0);
    issue("mov_a", 3'd7, 2'd3, 2'd0, 2'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("result_held", 32'({result, zero_flag, carry_flag}), 32'({8'hFF, 1'b0, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
